heap_engine: RTL and testbench
==============================

Name: heap_engine

Overview:
- Multi-cycle binary min-heap coprocessor sitting directly downstream of the execute stage.
- Execute forwards each custom push_heap/pop_heap instruction as a request carrying operand value and destination register.
- The engine performs the heap update with one sift level per cycle and returns a single-cycle response for register write-back.
- Keys are compared as unsigned DATA_W-bit values.

Parameters:
- DATA_W, 32, key/data width
- DEPTH, 16, heap capacity in entries (power of two, ≥2)
- IDX_W, $clog2(DEPTH), index width; count register is IDX_W+1 bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  execute presents a request
- req_ready  out  1  engine accepts a request (high only in IDLE)
- req_op  in  2  0=PUSH, 1=POP, 2=PEEK, 3=CLEAR
- req_data  in  DATA_W  key for PUSH (ignored otherwise)
- req_rd  in  5  destination register, echoed on response
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  DATA_W  result value
- rsp_rd  out  5  echoed req_rd
- rsp_err  out  1  overflow/underflow flag
- count  out  IDX_W+1  current number of entries
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, count=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0.
  - Heap storage is not cleared; contents are don't-care.
  - Reset mid-operation aborts the operation: no response, heap empty.
- FSM states:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready. Latch req_rd and act per op:
    - PUSH, not full: heap[count]<=req_data; count++; idx<=old count; go to SIFT_UP.
    - PUSH, full: rsp_err=1, rsp_data=0, no state change; go to RESP.
    - POP, not empty: result<=heap[0]; heap[0]<=heap[count-1]; count--; idx<=0; go to SIFT_DOWN.
    - POP, empty: rsp_err=1, rsp_data=0; go to RESP.
    - PEEK: result=heap[0], err=0 if not empty; err=1, data=0 if empty; go to RESP.
    - CLEAR: count<=0; rsp_data=0, err=0; go to RESP.
  - SIFT_UP: parent=(idx-1)>>1.
    - If idx==0 or heap[parent]<=heap[idx], go to RESP.
    - Otherwise swap the two entries and set idx<=parent.
  - SIFT_DOWN: l=2*idx+1, r=l+1; a child is valid if its index < count.
    - c = smaller valid child; the left child wins ties.
    - If no valid child or heap[c]>=heap[idx], go to RESP.
    - Otherwise swap and set idx<=c.
  - RESP: rsp_valid=1 for exactly this cycle; go to IDLE.
    - rsp_data: new count for a successful PUSH; popped/peeked key for POP/PEEK.
- Latency (accept edge = cycle 0):
  - rsp_valid is high in cycle 2 for the minimum sift case (push to empty, pop leaving 0 or 1 entry).
  - Add 1 cycle per swap; worst case is 2+log2(DEPTH).
  - Error, PEEK and CLEAR responses appear in cycle 1.
- Equal keys never swap, so ordering among duplicates is not preserved.
- count/full/empty update at the accept edge.
- req_* inputs are ignored while req_ready=0.
- No requests are accepted during RESP; throughput is at most one op per 2 cycles.
- Heap invariant required at every IDLE: heap[(i-1)>>1] <= heap[i] for all 0 < i < count.

Decomposition:
- Package heap_pkg holds:
  - op encodings HEAP_PUSH/POP/PEEK/CLEAR
  - FSM state enum IDLE/SIFT_UP/SIFT_DOWN/RESP
  - DEFAULT_DEPTH
- Sub-module heap_child_select (combinational): takes idx, count and both child keys; returns child index, valid, and swap-needed for SIFT_DOWN.

Test Plan:
- Reset, then PUSH 5,3,8,1 with rd=10 → rsp_data 1,2,3,4, err=0. PEEK → 1. count=4.
- Four POPs from the above → rsp_data 1,3,5,8 in order. empty=1 after the last.
- POP on empty, rd=7 → rsp_valid in cycle 1, rsp_err=1, rsp_data=0, rsp_rd=7. count stays 0.
- Fill DEPTH=16 with descending keys 16..1 → each push sifts to the root, last response in cycle 2+4. 17th PUSH → err=1, count=16.
- PUSH 4,4,4 then POP ×3 → data 4,4,4, no swaps. CLEAR with 2 entries → count=0, rsp_data=0.
- Assert reset during a SIFT_DOWN → no rsp_valid afterwards, count=0. Next PUSH 9 → rsp_data=1, then POP → 9.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared encodings for the heap coprocessor: request opcodes, FSM states and the
// default capacity.
package heap_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        HEAP_PUSH  = 2'd0,
        HEAP_POP   = 2'd1,
        HEAP_PEEK  = 2'd2,
        HEAP_CLEAR = 2'd3
    } heap_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2,
        RESP      = 2'd3
    } heap_state_e;

endpackage

// File: rtl/heap_child_select.sv
// Sift-down helper: picks the smaller valid child of idx (left wins ties) and
// reports whether it must be swapped with the current entry.
module heap_child_select
    import heap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W:0]    count,
    input  logic [DATA_W-1:0] key_l,
    input  logic [DATA_W-1:0] key_r,
    input  logic [DATA_W-1:0] key_cur,
    output logic [IDX_W-1:0]  child,
    output logic              child_valid,
    output logic              child_less
);

    logic [IDX_W+1:0] l_full;
    logic [IDX_W+1:0] r_full;
    logic [IDX_W+1:0] count_ext;
    logic             r_valid;
    logic             take_r;

    // Child indices can exceed the array range; the extra bits keep the
    // validity compare against count exact.
    always_comb begin
        l_full      = {1'b0, idx, 1'b1};
        r_full      = l_full + (IDX_W+2)'(1);
        count_ext   = {1'b0, count};
        child_valid = l_full < count_ext;
        r_valid     = r_full < count_ext;
        take_r      = r_valid && (key_r < key_l);
        child       = take_r ? r_full[IDX_W-1:0] : l_full[IDX_W-1:0];
        child_less  = take_r ? (key_r < key_cur) : (key_l < key_cur);
    end

endmodule

// File: rtl/heap_engine.sv
// Binary min-heap coprocessor: accepts push/pop/peek/clear requests and sifts
// one level per cycle before returning a single-cycle response.
//
// state     | meaning
// IDLE      | ready for a request; push/pop set up the sift, others respond
// SIFT_UP   | bubble new entry toward the root, one swap per cycle
// SIFT_DOWN | push relocated tail entry toward the leaves, one swap per cycle
// RESP      | rsp_valid pulse, back to IDLE
module heap_engine
    import heap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    heap_state_e       state, state_next;
    logic [DATA_W-1:0] heap_mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  parent;
    logic [IDX_W-1:0]  l_addr;
    logic [IDX_W-1:0]  r_addr;
    logic [IDX_W-1:0]  child;
    logic              child_valid;
    logic              child_less;
    logic              accept;
    logic              up_done;
    logic              down_swap;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);

    assign parent    = (idx - IDX_W'(1)) >> 1;
    assign l_addr    = IDX_W'({idx, 1'b1});
    assign r_addr    = l_addr + IDX_W'(1);
    assign up_done   = (idx == '0) || (heap_mem[parent] <= heap_mem[idx]);
    assign down_swap = child_valid && child_less;

    heap_child_select #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_child_select (
        .idx         (idx),
        .count       (count),
        .key_l       (heap_mem[l_addr]),
        .key_r       (heap_mem[r_addr]),
        .key_cur     (heap_mem[idx]),
        .child       (child),
        .child_valid (child_valid),
        .child_less  (child_less)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        HEAP_PUSH: state_next = full  ? RESP : SIFT_UP;
                        HEAP_POP:  state_next = empty ? RESP : SIFT_DOWN;
                        default:   state_next = RESP;
                    endcase
                end
            end
            SIFT_UP:   if (up_done)    state_next = RESP;
            SIFT_DOWN: if (!down_swap) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Storage is deliberately left uninitialised on reset; count alone defines
    // which entries are live.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            idx      <= '0;
            rsp_data <= '0;
            rsp_rd   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rd <= req_rd;
                        case (req_op)
                            HEAP_PUSH: begin
                                if (full) begin
                                    rsp_err  <= 1'b1;
                                    rsp_data <= '0;
                                end else begin
                                    rsp_err  <= 1'b0;
                                    rsp_data <= DATA_W'(count + (IDX_W+1)'(1));
                                    heap_mem[count[IDX_W-1:0]] <= req_data;
                                    count    <= count + (IDX_W+1)'(1);
                                    idx      <= count[IDX_W-1:0];
                                end
                            end
                            HEAP_POP: begin
                                if (empty) begin
                                    rsp_err  <= 1'b1;
                                    rsp_data <= '0;
                                end else begin
                                    rsp_err     <= 1'b0;
                                    rsp_data    <= heap_mem[0];
                                    heap_mem[0] <= heap_mem[IDX_W'(count - (IDX_W+1)'(1))];
                                    count       <= count - (IDX_W+1)'(1);
                                    idx         <= '0;
                                end
                            end
                            HEAP_PEEK: begin
                                rsp_err  <= empty;
                                rsp_data <= empty ? '0 : heap_mem[0];
                            end
                            default: begin
                                count    <= '0;
                                rsp_err  <= 1'b0;
                                rsp_data <= '0;
                            end
                        endcase
                    end
                end
                SIFT_UP: begin
                    if (!up_done) begin
                        heap_mem[parent] <= heap_mem[idx];
                        heap_mem[idx]    <= heap_mem[parent];
                        idx              <= parent;
                    end
                end
                SIFT_DOWN: begin
                    if (down_swap) begin
                        heap_mem[child] <= heap_mem[idx];
                        heap_mem[idx]   <= heap_mem[child];
                        idx             <= child;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_engine.sv
// Self-checking bench for heap_engine: directed vector table, descending fill,
// randomized ops against a queue-based priority-queue model, reset abort.
module tb_heap_engine;
    import heap_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'd0;
    logic [DATA_W-1:0] req_data = '0;
    logic [4:0]        req_rd = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_err;
    logic [IDX_W:0]    count;
    logic              full;
    logic              empty;

    heap_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_rd    (req_rd),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] model[$];

    typedef struct {
        heap_op_e    op;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_count;
        int          exp_lat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: the heap is just a multiset; a pop returns its minimum.
    task automatic model_op(input heap_op_e op, input logic [31:0] data,
                            output logic [31:0] d, output logic e);
        int p;
        d = '0;
        e = 1'b0;
        case (op)
            HEAP_PUSH:
                if (model.size() == DEPTH) e = 1'b1;
                else begin
                    model.push_back(data);
                    d = 32'(model.size());
                end
            HEAP_POP, HEAP_PEEK:
                if (model.size() == 0) e = 1'b1;
                else begin
                    p = 0;
                    for (int i = 1; i < model.size(); i++)
                        if (model[i] < model[p]) p = i;
                    d = model[p];
                    if (op == HEAP_POP) model.delete(p);
                end
            default: model.delete();
        endcase
    endtask

    task automatic run_op(input heap_op_e op, input logic [31:0] data, input logic [4:0] rd,
                          output logic [31:0] d, output logic e, output logic [4:0] r,
                          output int lat);
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = $urandom;
        req_rd    = 5'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data;
        e = rsp_err;
        r = rsp_rd;
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'(rsp_valid), 64'(1));
            lat = -1;
        end else begin
            @(posedge clk); #1;
            chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, md;
        logic        e, me;
        logic [4:0]  r, rd;
        int          lat, pre, swaps, t, sel;
        heap_op_e    op;
        logic [31:0] key;
        logic        seen;

        tbl.push_back('{HEAP_PUSH,  32'd5, 5'd10, 32'd1, 1'b0, 1, 2});
        tbl.push_back('{HEAP_PUSH,  32'd3, 5'd10, 32'd2, 1'b0, 2, 3});
        tbl.push_back('{HEAP_PUSH,  32'd8, 5'd10, 32'd3, 1'b0, 3, 2});
        tbl.push_back('{HEAP_PUSH,  32'd1, 5'd10, 32'd4, 1'b0, 4, 4});
        tbl.push_back('{HEAP_PEEK,  32'd0, 5'd11, 32'd1, 1'b0, 4, 1});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd12, 32'd1, 1'b0, 3, 3});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd13, 32'd3, 1'b0, 2, 3});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd14, 32'd5, 1'b0, 1, 2});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd15, 32'd8, 1'b0, 0, 2});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd7,  32'd0, 1'b1, 0, 1});
        tbl.push_back('{HEAP_PUSH,  32'd4, 5'd1,  32'd1, 1'b0, 1, 2});
        tbl.push_back('{HEAP_PUSH,  32'd4, 5'd2,  32'd2, 1'b0, 2, 2});
        tbl.push_back('{HEAP_PUSH,  32'd4, 5'd3,  32'd3, 1'b0, 3, 2});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd4,  32'd4, 1'b0, 2, 2});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd5,  32'd4, 1'b0, 1, 2});
        tbl.push_back('{HEAP_POP,   32'd0, 5'd6,  32'd4, 1'b0, 0, 2});
        tbl.push_back('{HEAP_PUSH,  32'd6, 5'd8,  32'd1, 1'b0, 1, 2});
        tbl.push_back('{HEAP_PUSH,  32'd2, 5'd9,  32'd2, 1'b0, 2, 3});
        tbl.push_back('{HEAP_CLEAR, 32'd0, 5'd3,  32'd0, 1'b0, 0, 1});
        tbl.push_back('{HEAP_PEEK,  32'd0, 5'd4,  32'd0, 1'b1, 0, 1});

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("rst_rsp_rd",    64'(rsp_rd),    64'(0));
        chk("rst_rsp_err",   64'(rsp_err),   64'(0));
        chk("rst_empty",     64'(empty),     64'(1));
        chk("rst_full",      64'(full),      64'(0));

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].data, tbl[i].rd, d, e, r, lat);
            model_op(tbl[i].op, tbl[i].data, md, me);
            chk("tbl_data",  64'(d),     64'(tbl[i].exp_data));
            chk("tbl_err",   64'(e),     64'(tbl[i].exp_err));
            chk("tbl_rd",    64'(r),     64'(tbl[i].rd));
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_empty", 64'(empty), 64'(tbl[i].exp_count == 0));
            chk("tbl_lat",   64'(lat),   64'(tbl[i].exp_lat));
        end

        // Descending fill: every new key is the smallest and climbs to the root.
        for (int k = DEPTH; k >= 1; k--) begin
            run_op(HEAP_PUSH, 32'(k), 5'd20, d, e, r, lat);
            model_op(HEAP_PUSH, 32'(k), md, me);
            t = DEPTH + 1 - k;
            swaps = 0;
            while (t > 1) begin
                t = t >> 1;
                swaps++;
            end
            chk("fill_data", 64'(d),   64'(DEPTH + 1 - k));
            chk("fill_err",  64'(e),   64'(0));
            chk("fill_lat",  64'(lat), 64'(2 + swaps));
        end
        chk("fill_full", 64'(full), 64'(1));
        run_op(HEAP_PUSH, 32'd99, 5'd21, d, e, r, lat);
        model_op(HEAP_PUSH, 32'd99, md, me);
        chk("ovf_err",   64'(e),     64'(1));
        chk("ovf_data",  64'(d),     64'(0));
        chk("ovf_rd",    64'(r),     64'(21));
        chk("ovf_lat",   64'(lat),   64'(1));
        chk("ovf_count", 64'(count), 64'(DEPTH));

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 99));
            op  = (sel < 50) ? HEAP_PUSH : (sel < 85) ? HEAP_POP :
                  (sel < 97) ? HEAP_PEEK : HEAP_CLEAR;
            key = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            rd  = 5'($urandom);
            pre = model.size();
            run_op(op, key, rd, d, e, r, lat);
            model_op(op, key, md, me);
            chk("rnd_data",  64'(d),     64'(md));
            chk("rnd_err",   64'(e),     64'(me));
            chk("rnd_rd",    64'(r),     64'(rd));
            chk("rnd_count", 64'(count), 64'(model.size()));
            if (me || op == HEAP_PEEK || op == HEAP_CLEAR)
                chk("rnd_lat_fast", 64'(lat), 64'(1));
            else if ((op == HEAP_PUSH && pre == 0) || (op == HEAP_POP && pre <= 2))
                chk("rnd_lat_min", 64'(lat), 64'(2));
            else
                chk("rnd_lat_range", 64'(lat >= 2 && lat <= 2 + IDX_W), 64'(1));
        end

        // Reset while a pop is still sifting down must abort without a response.
        run_op(HEAP_CLEAR, 32'd0, 5'd0, d, e, r, lat);
        model_op(HEAP_CLEAR, 32'd0, md, me);
        for (int k = 1; k <= 5; k++) begin
            run_op(HEAP_PUSH, 32'(k * 10), 5'd1, d, e, r, lat);
            model_op(HEAP_PUSH, 32'(k * 10), md, me);
        end
        req_valid = 1'b1;
        req_op    = HEAP_POP;
        req_rd    = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_busy", 64'(rsp_valid), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model.delete();
        seen = 1'b0;
        repeat (8) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_rsp", 64'(seen),     64'(0));
        chk("abort_count",  64'(count),    64'(0));
        chk("abort_empty",  64'(empty),    64'(1));
        chk("abort_data",   64'(rsp_data), 64'(0));
        run_op(HEAP_PUSH, 32'd9, 5'd2, d, e, r, lat);
        chk("post_push", 64'(d), 64'(1));
        run_op(HEAP_POP, 32'd0, 5'd3, d, e, r, lat);
        chk("post_pop",     64'(d),     64'(9));
        chk("post_pop_err", 64'(e),     64'(0));
        chk("post_count",   64'(count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
